// File: rtl/car_reset_seq.sv
// Staged reset sequencer for the arcade core: releases video, CPU and sound resets
// in order after DCM lock, restarts on a debounced button, and re-resets CPU/sound on watchdog expiry.
module car_reset_seq #(
    parameter int HOLD_CYCLES  = 4095,
    parameter int STAGE_CYCLES = 255,
    parameter int WDOG_CYCLES  = 1048575,
    parameter int DEB_CYCLES   = 1023,
    parameter int CW           = 20
) (
    input  logic       sysclk,
    input  logic       reset_n,
    input  logic       dcm_locked,
    input  logic       button,
    input  logic       wdog_en,
    input  logic       wdog_clr,
    output logic       reset_vid,
    output logic       reset_cpu,
    output logic       reset_snd,
    output logic       wdog_fired,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_VID  = 3'd1,
        S_CPU  = 3'd2,
        S_RUN  = 3'd3,
        S_WDOG = 3'd4
    } st_t;

    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
    localparam logic [CW-1:0] WDOG_LAST  = CW'(WDOG_CYCLES - 1);
    localparam logic [CW-1:0] DEB_MAX    = CW'(DEB_CYCLES);

    st_t           st;
    logic          lock_m, lock_s;
    logic          btn_m, btn_s;
    logic [CW-1:0] deb_cnt;
    logic          btn_db;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wcnt;

    assign state  = st;
    assign btn_db = (deb_cnt == DEB_MAX);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
        end else begin
            lock_m <= dcm_locked;
            lock_s <= lock_m;
            btn_m  <= button;
            btn_s  <= btn_m;
        end
    end

    // Saturating debounce: only a press held DEB_CYCLES synchronized cycles counts.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n)
            deb_cnt <= '0;
        else if (!btn_s)
            deb_cnt <= '0;
        else if (deb_cnt != DEB_MAX)
            deb_cnt <= deb_cnt + 1'b1;
    end

    // Outputs are assigned alongside every state change so they track state on the same edge.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            st         <= S_HOLD;
            cnt        <= '0;
            wcnt       <= '0;
            reset_vid  <= 1'b1;
            reset_cpu  <= 1'b1;
            reset_snd  <= 1'b1;
            wdog_fired <= 1'b0;
        end else if (!lock_s || btn_db) begin
            st        <= S_HOLD;
            cnt       <= '0;
            wcnt      <= '0;
            reset_vid <= 1'b1;
            reset_cpu <= 1'b1;
            reset_snd <= 1'b1;
            if (btn_db)
                wdog_fired <= 1'b0;
        end else begin
            case (st)
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        st        <= S_VID;
                        cnt       <= '0;
                        reset_vid <= 1'b0;
                        reset_cpu <= 1'b1;
                        reset_snd <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_VID: begin
                    if (cnt == STAGE_LAST) begin
                        st        <= S_CPU;
                        cnt       <= '0;
                        reset_vid <= 1'b0;
                        reset_cpu <= 1'b0;
                        reset_snd <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CPU: begin
                    if (cnt == STAGE_LAST) begin
                        st        <= S_RUN;
                        cnt       <= '0;
                        wcnt      <= '0;
                        reset_vid <= 1'b0;
                        reset_cpu <= 1'b0;
                        reset_snd <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    // A kick on the terminal count still wins, so the counter never wraps.
                    if (!wdog_en || wdog_clr) begin
                        wcnt <= '0;
                    end else if (wcnt == WDOG_LAST) begin
                        st         <= S_WDOG;
                        cnt        <= '0;
                        wdog_fired <= 1'b1;
                        reset_vid  <= 1'b0;
                        reset_cpu  <= 1'b1;
                        reset_snd  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_WDOG: begin
                    if (cnt == STAGE_LAST) begin
                        st        <= S_CPU;
                        cnt       <= '0;
                        reset_vid <= 1'b0;
                        reset_cpu <= 1'b0;
                        reset_snd <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st        <= S_HOLD;
                    cnt       <= '0;
                    wcnt      <= '0;
                    reset_vid <= 1'b1;
                    reset_cpu <= 1'b1;
                    reset_snd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_car_reset_seq.sv
// Directed bench for car_reset_seq with short cycle parameters; expected latencies hand-derived.
module tb_car_reset_seq;

    logic       sysclk = 1'b0;
    logic       reset_n, dcm_locked, button, wdog_en, wdog_clr;
    logic       reset_vid, reset_cpu, reset_snd, wdog_fired;
    logic [2:0] state;

    int pass_cnt = 0;
    int total    = 0;

    car_reset_seq #(
        .HOLD_CYCLES(16), .STAGE_CYCLES(4), .WDOG_CYCLES(32), .DEB_CYCLES(3), .CW(20)
    ) dut (
        .sysclk(sysclk), .reset_n(reset_n), .dcm_locked(dcm_locked), .button(button),
        .wdog_en(wdog_en), .wdog_clr(wdog_clr), .reset_vid(reset_vid), .reset_cpu(reset_cpu),
        .reset_snd(reset_snd), .wdog_fired(wdog_fired), .state(state)
    );

    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic cond(input int sel);
        case (sel)
            0: return state == 3'd0;
            1: return reset_vid == 1'b0;
            2: return reset_cpu == 1'b0;
            3: return reset_snd == 1'b0;
            4: return state == 3'd4;
            5: return state == 3'd2;
            default: return state == 3'd3;
        endcase
    endfunction

    // Counts edges until the selected condition holds; returns limit on timeout.
    task automatic wait_cond(input int sel, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cond(sel) && n < limit);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dcm_locked = 1'b1; button = 1'b0; wdog_en = 1'b0; wdog_clr = 1'b0;
        #23;
        total++;
        if ({state, reset_vid, reset_cpu, reset_snd, wdog_fired} !== {3'd0, 4'b1110})
            $display("FAIL reset_state: got st=%0d r=%b%b%b f=%b, want st=0 r=111 f=0",
                     state, reset_vid, reset_cpu, reset_snd, wdog_fired);
        else pass_cnt++;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_powerup();
        int n;
        wait_cond(1, 40, n);
        total++;
        if (n !== 18 || state !== 3'd1) $display("FAIL pwr_vid: got n=%0d st=%0d, want n=18 st=1", n, state);
        else pass_cnt++;
        wait_cond(2, 20, n);
        total++;
        if (n !== 4 || state !== 3'd2) $display("FAIL pwr_cpu: got n=%0d st=%0d, want n=4 st=2", n, state);
        else pass_cnt++;
        wait_cond(3, 20, n);
        total++;
        if (n !== 4 || state !== 3'd3) $display("FAIL pwr_snd: got n=%0d st=%0d, want n=4 st=3", n, state);
        else pass_cnt++;
    endtask

    task automatic drop_lock(input string nm);
        int n;
        dcm_locked = 1'b0;
        tick();
        dcm_locked = 1'b1;
        wait_cond(0, 20, n);
        total++;
        if (n !== 2 || {reset_vid, reset_cpu, reset_snd} !== 3'b111)
            $display("FAIL %s: got n=%0d r=%b%b%b, want n=2 r=111", nm, n, reset_vid, reset_cpu, reset_snd);
        else pass_cnt++;
    endtask

    task automatic test_lock_loss();
        int n;
        drop_lock("lock_run");
        wait_cond(5, 40, n);
        total++;
        if (n !== 20) $display("FAIL relock_cpu: got n=%0d, want 20", n);
        else pass_cnt++;
        drop_lock("lock_cpu");
        wait_cond(1, 40, n);
        total++;
        if (n !== 16) $display("FAIL relock_vid: got n=%0d, want 16", n);
        else pass_cnt++;
        wait_cond(2, 20, n);
        total++;
        if (n !== 4) $display("FAIL relock_cpu2: got n=%0d, want 4", n);
        else pass_cnt++;
        wait_cond(3, 20, n);
        total++;
        if (n !== 4 || state !== 3'd3) $display("FAIL relock_run: got n=%0d st=%0d, want n=4 st=3", n, state);
        else pass_cnt++;
    endtask

    task automatic test_button();
        int n;
        int first;
        logic left;
        left = 1'b0;
        button = 1'b1;
        tick(); tick();
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state !== 3'd3) left = 1'b1;
        end
        total++;
        if (left !== 1'b0) $display("FAIL btn_glitch: left RUN, got 1 want 0");
        else pass_cnt++;
        first = -1;
        button = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (state === 3'd0 && first < 0) first = i;
        end
        button = 1'b0;
        total++;
        if (first !== 6 || {reset_vid, reset_cpu, reset_snd} !== 3'b111)
            $display("FAIL btn_hold: got edge=%0d r=%b%b%b, want edge=6 r=111", first, reset_vid, reset_cpu, reset_snd);
        else pass_cnt++;
        wait_cond(1, 40, n);
        total++;
        if (n !== 19) $display("FAIL btn_restart_vid: got n=%0d, want 19", n);
        else pass_cnt++;
        wait_cond(6, 20, n);
        total++;
        if (n !== 8) $display("FAIL btn_restart_run: got n=%0d, want 8", n);
        else pass_cnt++;
    endtask

    task automatic test_wdog_fire();
        int n;
        wdog_en = 1'b1;
        wait_cond(4, 60, n);
        total++;
        if (n !== 32 || wdog_fired !== 1'b1) $display("FAIL wdog_fire: got n=%0d f=%b, want n=32 f=1", n, wdog_fired);
        else pass_cnt++;
        total++;
        if ({reset_vid, reset_cpu, reset_snd} !== 3'b011)
            $display("FAIL wdog_outs: got r=%b%b%b, want 011", reset_vid, reset_cpu, reset_snd);
        else pass_cnt++;
        wait_cond(5, 20, n);
        total++;
        if (n !== 4 || {reset_vid, reset_cpu, reset_snd} !== 3'b001)
            $display("FAIL wdog_cpu: got n=%0d r=%b%b%b, want n=4 r=001", n, reset_vid, reset_cpu, reset_snd);
        else pass_cnt++;
        wait_cond(6, 20, n);
        total++;
        if (n !== 4 || wdog_fired !== 1'b1) $display("FAIL wdog_run: got n=%0d f=%b, want n=4 f=1", n, wdog_fired);
        else pass_cnt++;
    endtask

    task automatic test_wdog_kick();
        int n;
        logic left;
        left = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            wdog_clr = (k % 31 == 0);
            tick();
            if (state !== 3'd3) left = 1'b1;
        end
        wdog_clr = 1'b0;
        total++;
        if (left !== 1'b0) $display("FAIL kick_31: left RUN, got 1 want 0");
        else pass_cnt++;
        wdog_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (state !== 3'd3) left = 1'b1;
        end
        total++;
        if (left !== 1'b0) $display("FAIL wdog_dis: left RUN, got 1 want 0");
        else pass_cnt++;
        wdog_en = 1'b1;
        wdog_clr = 1'b1;
        tick();
        wdog_clr = 1'b0;
        for (int k = 0; k < 31; k++) begin
            tick();
            if (state !== 3'd3) left = 1'b1;
        end
        wdog_clr = 1'b1;
        tick();
        wdog_clr = 1'b0;
        total++;
        if (left !== 1'b0 || state !== 3'd3) $display("FAIL kick_exact: got st=%0d left=%b, want st=3 left=0", state, left);
        else pass_cnt++;
        wait_cond(4, 60, n);
        total++;
        if (n !== 32) $display("FAIL kick_refire: got n=%0d, want 32", n);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({state, reset_vid, reset_cpu, reset_snd, wdog_fired} !== {3'd0, 4'b1110})
            $display("FAIL reset_mid: got st=%0d r=%b%b%b f=%b, want st=0 r=111 f=0",
                     state, reset_vid, reset_cpu, reset_snd, wdog_fired);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_lock_loss();
        test_button();
        test_wdog_fire();
        test_wdog_kick();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
